// File: rtl/sync_delay_line.sv
// Fixed-depth shift register that keeps the {vsync, hsync, de} bundle aligned
// with the packed-word pipeline.
module sync_delay_line #(
    parameter int DEPTH = 2,
    parameter int W     = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int k = 1; k < DEPTH; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/pixel_packer.sv
// Serial-to-parallel pixel packer: gathers OUT_PCNT single pixels into one bus word,
// zero-pads the tail of a line and keeps the sync signals aligned with the words.
module pixel_packer #(
    parameter int PW       = 8,
    parameter int OUT_PCNT = 2,
    parameter int AW       = 11
) (
    input  logic                   i_pclk,
    input  logic                   i_arstn,
    input  logic                   i_vsync,
    input  logic                   i_hsync,
    input  logic                   i_de,
    input  logic                   i_valid,
    input  logic [PW-1:0]          i_data,
    output logic                   o_vsync,
    output logic                   o_hsync,
    output logic                   o_de,
    output logic                   o_valid,
    output logic [PW*OUT_PCNT-1:0] o_data,
    output logic                   o_pad,
    output logic [AW-1:0]          o_x,
    output logic [AW-1:0]          o_y
);

    localparam int CNT_W = (OUT_PCNT > 1) ? $clog2(OUT_PCNT) : 1;
    localparam int DW    = PW * OUT_PCNT;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(OUT_PCNT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    pack_q, pack_d;
    logic             done_q, done_d;
    logic             de_q;
    logic             valid_q, pad_q;
    logic [DW-1:0]    data_q;
    logic [AW-1:0]    x_q, y_q;
    logic             ode_prev_q, ovs_prev_q;

    logic             accept, flush;
    logic             ode_fall, ovs_fall;
    logic [DW-1:0]    flush_word;
    logic [2:0]       sync_dly;

    sync_delay_line #(
        .DEPTH (2),
        .W     (3)
    ) u_sync_dly (
        .clk_i  (i_pclk),
        .rst_ni (i_arstn),
        .d_i    ({i_vsync, i_hsync, i_de}),
        .q_o    (sync_dly)
    );

    assign o_vsync = sync_dly[2];
    assign o_hsync = sync_dly[1];
    assign o_de    = sync_dly[0];

    assign accept = i_vsync & i_hsync & i_de & i_valid;
    // A falling DE with a partial word pending; vsync low suppresses it.
    assign flush  = i_vsync & de_q & ~i_de & (cnt_q != '0);

    assign ode_fall = ode_prev_q & ~o_de;
    assign ovs_fall = ovs_prev_q & ~o_vsync;

    always_comb begin
        cnt_d  = cnt_q;
        pack_d = pack_q;
        done_d = 1'b0;
        if (!i_vsync) begin
            cnt_d = '0;
        end else if (flush) begin
            cnt_d = '0;
        end else if (accept) begin
            for (int k = 0; k < OUT_PCNT; k++) begin
                if (cnt_q == CNT_W'(k)) begin
                    pack_d[k*PW +: PW] = i_data;
                end
            end
            if (cnt_q == LAST_SLOT) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Slots at or beyond the fill level belong to an earlier word and are blanked.
    always_comb begin
        flush_word = '0;
        for (int k = 0; k < OUT_PCNT; k++) begin
            if (CNT_W'(k) < cnt_q) begin
                flush_word[k*PW +: PW] = pack_q[k*PW +: PW];
            end
        end
    end

    always_ff @(posedge i_pclk) begin
        if (!i_arstn) begin
            cnt_q      <= '0;
            pack_q     <= '0;
            done_q     <= 1'b0;
            de_q       <= 1'b0;
            valid_q    <= 1'b0;
            pad_q      <= 1'b0;
            data_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            ode_prev_q <= 1'b0;
            ovs_prev_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            pack_q     <= pack_d;
            done_q     <= done_d;
            de_q       <= i_de;
            valid_q    <= done_q | flush;
            pad_q      <= flush & ~done_q;
            if (done_q) begin
                data_q <= pack_q;
            end else if (flush) begin
                data_q <= flush_word;
            end
            ode_prev_q <= o_de;
            ovs_prev_q <= o_vsync;

            if (ode_fall || ovs_fall) begin
                x_q <= '0;
            end else if (valid_q) begin
                x_q <= x_q + 1'b1;
            end

            if (ovs_fall) begin
                y_q <= '0;
            end else if (ode_fall) begin
                y_q <= y_q + 1'b1;
            end
        end
    end

    assign o_valid = valid_q;
    assign o_pad   = pad_q;
    assign o_data  = data_q;
    assign o_x     = x_q;
    assign o_y     = y_q;

endmodule

// File: tb/tb_pixel_packer.sv
// Bench for pixel_packer: three instances (OUT_PCNT = 1, 2, 4) share one input
// stream and are checked against a pixel-list reference model.
module tb_pixel_packer;

    localparam int PW = 8;
    localparam int AW = 11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          arstn = 1'b0;
    logic          vs    = 1'b0;
    logic          hs    = 1'b0;
    logic          de    = 1'b0;
    logic          valid = 1'b0;
    logic [PW-1:0] data  = '0;

    logic          o_vs   [3];
    logic          o_hs   [3];
    logic          o_de_w [3];
    logic          o_val  [3];
    logic          o_pad_w[3];
    logic [AW-1:0] o_x_w  [3];
    logic [AW-1:0] o_y_w  [3];
    logic [7:0]    od_n1;
    logic [15:0]   od_n2;
    logic [31:0]   od_n4;

    pixel_packer #(.PW(PW), .OUT_PCNT(1), .AW(AW)) u_n1 (
        .i_pclk(clk), .i_arstn(arstn), .i_vsync(vs), .i_hsync(hs), .i_de(de),
        .i_valid(valid), .i_data(data),
        .o_vsync(o_vs[0]), .o_hsync(o_hs[0]), .o_de(o_de_w[0]), .o_valid(o_val[0]),
        .o_data(od_n1), .o_pad(o_pad_w[0]), .o_x(o_x_w[0]), .o_y(o_y_w[0])
    );

    pixel_packer #(.PW(PW), .OUT_PCNT(2), .AW(AW)) u_n2 (
        .i_pclk(clk), .i_arstn(arstn), .i_vsync(vs), .i_hsync(hs), .i_de(de),
        .i_valid(valid), .i_data(data),
        .o_vsync(o_vs[1]), .o_hsync(o_hs[1]), .o_de(o_de_w[1]), .o_valid(o_val[1]),
        .o_data(od_n2), .o_pad(o_pad_w[1]), .o_x(o_x_w[1]), .o_y(o_y_w[1])
    );

    pixel_packer #(.PW(PW), .OUT_PCNT(4), .AW(AW)) u_n4 (
        .i_pclk(clk), .i_arstn(arstn), .i_vsync(vs), .i_hsync(hs), .i_de(de),
        .i_valid(valid), .i_data(data),
        .o_vsync(o_vs[2]), .o_hsync(o_hs[2]), .o_de(o_de_w[2]), .o_valid(o_val[2]),
        .o_data(od_n4), .o_pad(o_pad_w[2]), .o_x(o_x_w[2]), .o_y(o_y_w[2])
    );

    function automatic int n_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] obs_data(input int i);
        if (i == 0) return {24'b0, od_n1};
        if (i == 1) return {16'b0, od_n2};
        return od_n4;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        int            inst;
        int            due;
        logic [31:0]   data;
        logic          pad;
        logic [AW-1:0] x;
        logic [AW-1:0] y;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   edge_n = 0;

    // Reference model: pixels gathered so far per instance, word/line indices.
    logic [PW-1:0] pend [3][4];
    int            pcnt [3];
    int            idx  [3];
    int            line;
    logic          prev_de, prev_vs;
    logic [2:0]    h1, h2;
    logic [31:0]   last_data [3];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, want, edge_n);
        end
    endtask

    task automatic push_word(input int i, input int due, input logic pad);
        exp_t        e;
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < n_of(i); k++) begin
            if (k < pcnt[i]) w[k*PW +: PW] = pend[i][k];
        end
        e.inst = i;
        e.due  = due;
        e.data = w;
        e.pad  = pad;
        e.x    = AW'(idx[i]);
        e.y    = AW'(line);
        exp_q.push_back(e);
        idx[i]++;
        pcnt[i] = 0;
    endtask

    // Called right after each rising edge with the inputs that edge sampled.
    task automatic model_step();
        logic vsf, def;
        exp_t keep[$];
        edge_n++;
        if (!arstn) begin
            for (int i = 0; i < 3; i++) begin
                pcnt[i]      = 0;
                idx[i]       = 0;
                last_data[i] = '0;
            end
            line    = 0;
            prev_de = 1'b0;
            prev_vs = 1'b0;
            h1      = '0;
            h2      = '0;
            foreach (exp_q[j]) if (exp_q[j].due < edge_n) keep.push_back(exp_q[j]);
            exp_q = keep;
            return;
        end
        h2  = h1;
        h1  = {vs, hs, de};
        vsf = prev_vs & ~vs;
        def = prev_de & ~de;
        for (int i = 0; i < 3; i++) begin
            if (!vs) begin
                pcnt[i] = 0;
            end else if (def && pcnt[i] != 0) begin
                push_word(i, edge_n, 1'b1);
            end else if (vs && hs && de && valid) begin
                pend[i][pcnt[i]] = data;
                pcnt[i]++;
                if (pcnt[i] == n_of(i)) push_word(i, edge_n + 1, 1'b0);
            end
        end
        if (vsf) begin
            line = 0;
            for (int i = 0; i < 3; i++) idx[i] = 0;
        end else if (def) begin
            line++;
            for (int i = 0; i < 3; i++) idx[i] = 0;
        end
        prev_de = de;
        prev_vs = vs;
    endtask

    task automatic check_outputs();
        int    jf;
        string nm;
        for (int i = 0; i < 3; i++) begin
            nm = $sformatf("N%0d", n_of(i));
            jf = -1;
            foreach (exp_q[j]) if (exp_q[j].inst == i && exp_q[j].due == edge_n) jf = j;
            check_val({nm, " o_valid"}, 32'(o_val[i]), 32'(jf >= 0));
            if (jf >= 0) begin
                check_val({nm, " o_data"}, obs_data(i), exp_q[jf].data);
                check_val({nm, " o_pad"}, 32'(o_pad_w[i]), 32'(exp_q[jf].pad));
                check_val({nm, " o_x"}, 32'(o_x_w[i]), 32'(exp_q[jf].x));
                check_val({nm, " o_y"}, 32'(o_y_w[i]), 32'(exp_q[jf].y));
                last_data[i] = exp_q[jf].data;
                exp_q.delete(jf);
            end else begin
                check_val({nm, " o_pad idle"}, 32'(o_pad_w[i]), 32'd0);
                check_val({nm, " o_data hold"}, obs_data(i), last_data[i]);
            end
            check_val({nm, " o_vsync"}, 32'(o_vs[i]), 32'(h2[2]));
            check_val({nm, " o_hsync"}, 32'(o_hs[i]), 32'(h2[1]));
            check_val({nm, " o_de"}, 32'(o_de_w[i]), 32'(h2[0]));
        end
    endtask

    task automatic check_xy_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("N%0d %s o_x", n_of(i), tag), 32'(o_x_w[i]), 32'd0);
            check_val($sformatf("N%0d %s o_y", n_of(i), tag), 32'(o_y_w[i]), 32'd0);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic r, input logic v, input logic h, input logic d,
                       input logic va, input logic [PW-1:0] px);
        arstn = r;
        vs    = v;
        hs    = h;
        de    = d;
        valid = va;
        data  = px;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic send_line(input int npix, input int valid_pct, input int hs_drop_pct,
                             input logic [PW-1:0] base, input logic rnd_data, input int gap);
        int   sent;
        logic va, h;
        sent = 0;
        while (sent < npix) begin
            va = (int'($urandom_range(0, 99)) < valid_pct);
            h  = !(int'($urandom_range(0, 99)) < hs_drop_pct);
            cyc(1'b1, 1'b1, h, 1'b1, va,
                rnd_data ? PW'($urandom_range(0, 255)) : base + PW'(sent));
            if (va && h) sent++;
        end
        repeat (gap) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic frame_gap(input int lo, input int hi);
        repeat (lo) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        repeat (hi) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check_xy_zero("reset");
        frame_gap(2, 2);

        // Full words, padded tail, and gappy valid inside one frame.
        send_line(6, 100, 0, 8'd1, 1'b0, 3);
        send_line(5, 100, 0, 8'd1, 1'b0, 3);
        for (int p = 0; p < 6; p++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, PW'(p + 1));
            cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hEE);
        end
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);

        // Fresh frame of three short lines so o_y walks 0,1,2.
        frame_gap(2, 2);
        repeat (3) send_line(4, 100, 0, 8'h41, 1'b0, 2);

        // vsync and DE drop together with a partial word pending: discarded.
        send_line(6, 100, 0, 8'h31, 1'b0, 0);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check_xy_zero("vsync fall");
        repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        send_line(4, 100, 0, 8'h10, 1'b0, 2);

        // Reset mid-line with three pixels pending in the 4-wide packer.
        send_line(7, 100, 0, 8'h51, 1'b0, 0);
        repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hAA);
        check_xy_zero("mid-line reset");
        send_line(4, 100, 0, 8'h61, 1'b0, 3);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Randomized frames: ragged line lengths, valid gaps, stray hsync drops.
        repeat (5) begin
            frame_gap(0, 2);
            repeat ($urandom_range(2, 4)) begin
                send_line($urandom_range(1, 9), $urandom_range(40, 100), 5, '0, 1'b1,
                          $urandom_range(1, 3));
            end
            repeat ($urandom_range(2, 3)) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        end

        repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check_val("pending words", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
